// File: rtl/one_max_display.sv
// Converts a captured fitness/generation pair to BCD by sequential double dabble
// and drives eight registered active-low seven-segment displays.
module one_max_display #(
    parameter int BLANK_LEADING = 1
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        load,
    input  logic [5:0]  fitness,
    input  logic [15:0] generation,
    output logic        busy,
    output logic        valid,
    output logic [6:0]  HEX0,
    output logic [6:0]  HEX1,
    output logic [6:0]  HEX2,
    output logic [6:0]  HEX3,
    output logic [6:0]  HEX4,
    output logic [6:0]  HEX5,
    output logic [6:0]  HEX6,
    output logic [6:0]  HEX7
);

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        DONE
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    state_t      state_reg;
    logic [4:0]  cnt_reg;
    logic [15:0] gen_shift_reg;
    logic [19:0] gen_bcd_reg;
    logic [5:0]  fit_shift_reg;
    logic [7:0]  fit_bcd_reg;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // The top digit of each field never reaches 5 before a shift (maxima are 6 and 6),
    // so only the lower digits need the add-3 correction.
    logic [15:0] gen_adj;
    logic [3:0]  fit_adj;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_gen_adj
            assign gen_adj[gi*4 +: 4] = (gen_bcd_reg[gi*4 +: 4] >= 4'd5) ?
                                        gen_bcd_reg[gi*4 +: 4] + 4'd3 :
                                        gen_bcd_reg[gi*4 +: 4];
        end
    endgenerate

    assign fit_adj = (fit_bcd_reg[3:0] >= 4'd5) ? fit_bcd_reg[3:0] + 4'd3 : fit_bcd_reg[3:0];

    // gen_lead[i] is set when digit i and every digit above it are zero.
    logic [4:1] gen_lead;
    logic [6:0] gen_seg [5];

    generate
        for (gi = 1; gi < 5; gi++) begin : g_lead
            if (gi == 4) begin : g_top
                assign gen_lead[gi] = (gen_bcd_reg[gi*4 +: 4] == 4'd0);
            end else begin : g_mid
                assign gen_lead[gi] = gen_lead[gi+1] && (gen_bcd_reg[gi*4 +: 4] == 4'd0);
            end
        end
        for (gi = 0; gi < 5; gi++) begin : g_seg
            if (gi == 0) begin : g_ones
                assign gen_seg[gi] = seg7(gen_bcd_reg[3:0]);
            end else begin : g_upper
                assign gen_seg[gi] = (BLANK_LEADING != 0 && gen_lead[gi]) ?
                                     SEG_BLANK : seg7(gen_bcd_reg[gi*4 +: 4]);
            end
        end
    endgenerate

    logic [6:0] fit_seg_tens;
    logic [6:0] fit_seg_ones;

    assign fit_seg_tens = (BLANK_LEADING != 0 && fit_bcd_reg[7:4] == 4'd0) ?
                          SEG_BLANK : seg7(fit_bcd_reg[7:4]);
    assign fit_seg_ones = seg7(fit_bcd_reg[3:0]);

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            gen_shift_reg <= '0;
            gen_bcd_reg   <= '0;
            fit_shift_reg <= '0;
            fit_bcd_reg   <= '0;
            busy          <= 1'b0;
            valid         <= 1'b0;
            HEX0          <= SEG_BLANK;
            HEX1          <= SEG_BLANK;
            HEX2          <= SEG_BLANK;
            HEX3          <= SEG_BLANK;
            HEX4          <= SEG_BLANK;
            HEX5          <= SEG_BLANK;
            HEX6          <= SEG_BLANK;
            HEX7          <= SEG_BLANK;
        end else begin
            case (state_reg)
                IDLE: begin
                    valid <= 1'b0;
                    if (load) begin
                        gen_shift_reg <= generation;
                        fit_shift_reg <= fitness;
                        gen_bcd_reg   <= '0;
                        fit_bcd_reg   <= '0;
                        cnt_reg       <= '0;
                        busy          <= 1'b1;
                        state_reg     <= CONVERT;
                    end
                end
                CONVERT: begin
                    if (cnt_reg == 5'd16) begin
                        state_reg <= DONE;
                        valid     <= 1'b1;
                        HEX0      <= gen_seg[0];
                        HEX1      <= gen_seg[1];
                        HEX2      <= gen_seg[2];
                        HEX3      <= gen_seg[3];
                        HEX4      <= gen_seg[4];
                        HEX5      <= SEG_BLANK;
                        HEX6      <= fit_seg_ones;
                        HEX7      <= fit_seg_tens;
                    end else begin
                        gen_bcd_reg   <= {gen_bcd_reg[18:16], gen_adj, gen_shift_reg[15]};
                        gen_shift_reg <= {gen_shift_reg[14:0], 1'b0};
                        // Fitness finishes after 6 iterations and is then held.
                        if (cnt_reg < 5'd6) begin
                            fit_bcd_reg   <= {fit_bcd_reg[6:4], fit_adj, fit_shift_reg[5]};
                            fit_shift_reg <= {fit_shift_reg[4:0], 1'b0};
                        end
                        cnt_reg <= cnt_reg + 5'd1;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                    busy      <= 1'b0;
                    valid     <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                    busy      <= 1'b0;
                    valid     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_one_max_display.sv
// Directed and randomised bench for one_max_display; both blanking variants share stimulus.
module tb_one_max_display;

    logic        CLOCK_50 = 1'b0;
    logic        reset;
    logic        load;
    logic [5:0]  fitness;
    logic [15:0] generation;
    logic        busy, valid, busy_z, valid_z;
    logic [6:0]  h [8];
    logic [6:0]  hz [8];

    int errors = 0;
    int checks = 0;
    int valid_cnt = 0;
    int expected_valids = 0;

    always #5 CLOCK_50 = ~CLOCK_50;

    one_max_display #(.BLANK_LEADING(1)) dut (
        .CLOCK_50(CLOCK_50), .reset(reset), .load(load),
        .fitness(fitness), .generation(generation),
        .busy(busy), .valid(valid),
        .HEX0(h[0]), .HEX1(h[1]), .HEX2(h[2]), .HEX3(h[3]),
        .HEX4(h[4]), .HEX5(h[5]), .HEX6(h[6]), .HEX7(h[7])
    );

    one_max_display #(.BLANK_LEADING(0)) dut_z (
        .CLOCK_50(CLOCK_50), .reset(reset), .load(load),
        .fitness(fitness), .generation(generation),
        .busy(busy_z), .valid(valid_z),
        .HEX0(hz[0]), .HEX1(hz[1]), .HEX2(hz[2]), .HEX3(hz[3]),
        .HEX4(hz[4]), .HEX5(hz[5]), .HEX6(hz[6]), .HEX7(hz[7])
    );

    always @(negedge CLOCK_50) if (valid === 1'b1) valid_cnt++;

    function automatic logic [6:0] seg(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // Digit at decimal position pos of v; leading zeros blanked when requested.
    function automatic logic [6:0] model(input int v, input int pos, input bit blank);
        int p = 1;
        for (int i = 0; i < pos; i++) p = p * 10;
        if (blank && pos > 0 && v < p) return 7'b1111111;
        return seg((v / p) % 10);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_display(input int f, input int g);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("hex%0d f=%0d g=%0d", i, f, g), h[i], model(g, i, 1'b1));
            chk($sformatf("hexz%0d f=%0d g=%0d", i, f, g), hz[i], model(g, i, 1'b0));
        end
        chk("hex5", h[5], 7'b1111111);
        chk("hexz5", hz[5], 7'b1111111);
        chk($sformatf("hex6 f=%0d", f), h[6], model(f, 0, 1'b1));
        chk($sformatf("hex7 f=%0d", f), h[7], model(f, 1, 1'b1));
        chk($sformatf("hexz6 f=%0d", f), hz[6], model(f, 0, 1'b0));
        chk($sformatf("hexz7 f=%0d", f), hz[7], model(f, 1, 1'b0));
    endtask

    task automatic check_blank(input string tag);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("%s hex%0d", tag, i), h[i], 7'b1111111);
            chk($sformatf("%s hexz%0d", tag, i), hz[i], 7'b1111111);
        end
    endtask

    // Called at the negedge following the accepting edge k.
    task automatic wait_done(input int f, input int g);
        int n = 0;
        while (valid !== 1'b1 && n < 40) begin
            @(negedge CLOCK_50);
            n++;
            if (valid !== 1'b1) chk("busy_convert", busy, 1'b1);
        end
        chk($sformatf("latency f=%0d g=%0d", f, g), n, 17);
        chk("busy_done", busy, 1'b1);
        chk("valid_z", valid_z, 1'b1);
        expected_valids++;
        check_display(f, g);
        @(negedge CLOCK_50);
        chk("busy_idle", busy, 1'b0);
        chk("valid_drop", valid, 1'b0);
        $display("request f=%0d g=%0d latency=%0d", f, g, n);
    endtask

    task automatic run_req(input int f, input int g);
        load = 1'b1;
        fitness = f[5:0];
        generation = g[15:0];
        @(negedge CLOCK_50);
        load = 1'b0;
        chk("busy_after_load", busy, 1'b1);
        wait_done(f, g);
    endtask

    int vc_snap;
    int dir_f [6] = '{0, 9, 10, 59, 60, 63};
    int dir_g [6] = '{9, 10, 99, 100, 9999, 10000};

    initial begin
        reset = 1'b1;
        load = 1'b1;
        fitness = 6'd17;
        generation = 16'd321;
        repeat (3) @(negedge CLOCK_50);
        chk("reset_busy", busy, 1'b0);
        chk("reset_valid", valid, 1'b0);
        check_blank("reset");
        reset = 1'b0;
        load = 1'b0;
        @(negedge CLOCK_50);
        chk("idle_busy", busy, 1'b0);

        run_req(32, 0);
        chk("r25_hex7", h[7], 7'b0110000);
        chk("r25_hex6", h[6], 7'b0100100);
        chk("r25_hex1", h[1], 7'b1111111);
        chk("r25_hex0", h[0], 7'b1000000);
        repeat (5) @(negedge CLOCK_50);
        chk("hold_hex7", h[7], 7'b0110000);
        chk("hold_hex0", h[0], 7'b1000000);

        run_req(63, 65535);
        chk("r26_hex7", h[7], 7'b0000010);
        chk("r26_hex6", h[6], 7'b0110000);
        chk("r26_hex5", h[5], 7'b1111111);
        chk("r26_hex4", h[4], 7'b0000010);
        chk("r26_hex3", h[3], 7'b0010010);
        chk("r26_hex2", h[2], 7'b0010010);
        chk("r26_hex1", h[1], 7'b0110000);
        chk("r26_hex0", h[0], 7'b0010010);

        // Load held high throughout busy with changing operands.
        load = 1'b1;
        fitness = 6'd5;
        generation = 16'd100;
        @(negedge CLOCK_50);
        fitness = 6'd9;
        generation = 16'd7;
        wait_done(5, 100);
        @(negedge CLOCK_50);
        chk("b2b_accept", busy, 1'b1);
        load = 1'b0;
        wait_done(9, 7);

        // Abort mid-conversion; load during reset is discarded.
        load = 1'b1;
        fitness = 6'd20;
        generation = 16'd12345;
        @(negedge CLOCK_50);
        load = 1'b0;
        repeat (8) @(negedge CLOCK_50);
        reset = 1'b1;
        load = 1'b1;
        @(negedge CLOCK_50);
        reset = 1'b0;
        load = 1'b0;
        chk("abort_busy", busy, 1'b0);
        chk("abort_valid", valid, 1'b0);
        check_blank("abort");
        vc_snap = valid_cnt;
        repeat (25) @(negedge CLOCK_50);
        chk("abort_no_valid", valid_cnt, vc_snap);
        chk("abort_idle", busy, 1'b0);
        run_req(1, 1);

        run_req(0, 42);
        chk("r29_hexz7", hz[7], 7'b1000000);
        chk("r29_hexz6", hz[6], 7'b1000000);
        chk("r29_hexz4", hz[4], 7'b1000000);
        chk("r29_hexz2", hz[2], 7'b1000000);
        chk("r29_hexz1", hz[1], 7'b0011001);
        chk("r29_hexz0", hz[0], 7'b0100100);
        chk("r29_hex7", h[7], 7'b1111111);
        chk("r29_hex6", h[6], 7'b1000000);

        for (int i = 0; i < 6; i++) run_req(dir_f[i], dir_g[i]);

        for (int i = 0; i < 1000; i++) begin
            run_req(int'($urandom_range(0, 63)), int'($urandom_range(0, 65535)));
        end

        repeat (3) @(negedge CLOCK_50);
        chk("valid_count", valid_cnt, expected_valids);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
